debug_reg_dumper: RTL

Debug readout stage placed downstream of the single-cycle RISC-V computer top. It consumes that top's PC and debug register-read port, and drives the register select itself.
On a start pulse it snapshots PC, then walks debug_reg_select through x0..x31. Each value is serialised over a UART 8N1 line as one fixed binary frame for a host-side dump tool.

---
 rtl/dbg_pkg.sv | 16 +
 rtl/debug_reg_dumper_uart_tx.sv | 56 +++++
 rtl/debug_reg_dumper.sv | 114 +++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug register dumper: FSM states and frame geometry.
package dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEL,
        ST_CAP,
        ST_FIN
    } state_t;

    localparam int FRAME_BYTES = 133;
    localparam int NUM_REGS    = 32;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/debug_reg_dumper_uart_tx.sv
// UART 8N1 transmitter: ready is high only while idle, so back-to-back bytes
// are separated by exactly one idle-high cycle.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_active;
    logic             r_tx;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [8:0]       r_shift;

    // r_bit indexes the bit currently on the line: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
        end else if (!r_active) begin
            if (valid) begin
                r_active <= 1'b1;
                r_tx     <= 1'b0;
                r_shift  <= {1'b1, data};
                r_cnt    <= '0;
                r_bit    <= '0;
            end
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit == 4'd9) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_tx    <= r_shift[0];
                r_shift <= {1'b0, r_shift[8:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ready = ~r_active;
    assign tx    = r_tx;

endmodule

// File: rtl/debug_reg_dumper.sv
// Debug readout: on start, serialises HEADER, the latched PC and x0..x31
// (each MSB first) as one 133-byte UART frame, walking debug_reg_select itself.
module debug_reg_dumper
    import dbg_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_in,
    input  logic [31:0] debug_reg_in,
    output logic [4:0]  debug_reg_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [4:0]  r_idx;
    logic [4:0]  r_sel;
    logic [31:0] r_shift;
    logic        r_done;

    logic        w_valid;
    logic        w_accept;
    logic        w_tx_ready;
    logic        w_group_end;
    logic        w_last;
    logic [7:0]  w_byte;

    // Every 4th byte after the header closes a 32-bit word (PC or a register)
    assign w_group_end = (r_cnt != 8'd0) && (r_cnt[1:0] == 2'b00);
    assign w_last      = (r_cnt == 8'(FRAME_BYTES - 1));
    assign w_byte      = (r_cnt == 8'd0) ? HEADER_BYTE : r_shift[31:24];
    assign w_accept    = w_valid && w_tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        unique case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SEND;
            ST_SEND: begin
                w_valid = 1'b1;
                if (w_tx_ready && w_group_end) begin
                    w_state_next = w_last ? ST_FIN : ST_SEL;
                end
            end
            ST_SEL:  w_state_next = ST_CAP;
            ST_CAP:  w_state_next = ST_SEND;
            ST_FIN:  if (r_done) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_sel  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_sel <= '0;
                    if (start) begin
                        r_shift <= pc_in;
                        r_cnt   <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt != 8'd0) r_shift <= {r_shift[23:0], 8'h00};
                        if (w_group_end && !w_last) r_idx <= 5'(r_cnt[7:2] - 6'd1);
                    end
                end
                ST_SEL:  r_sel <= r_idx;
                // Select was registered one cycle earlier, so the read path has settled
                ST_CAP:  r_shift <= debug_reg_in;
                ST_FIN:  if (!r_done && w_tx_ready) r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (w_byte),
        .valid (w_valid),
        .ready (w_tx_ready),
        .tx    (tx)
    );

    assign debug_reg_select = r_sel;
    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;

endmodule
